// File: rtl/conv_seq_pkg.sv
// Shared constants, address widths and FSM state type for the convolution sequencer.
package conv_seq_pkg;

  localparam int IMG_W     = 32;
  localparam int K         = 5;
  localparam int NUM_MAPS  = 6;
  localparam int DW        = 8;
  localparam int YW        = 16;
  localparam int DRAIN_MAX = 64;

  localparam int PIX_N   = IMG_W * IMG_W;
  localparam int KK      = K * K;
  localparam int OUT_PIX = (IMG_W - K + 1) * (IMG_W - K + 1);
  localparam int TOTAL   = NUM_MAPS * OUT_PIX;

  localparam int XAW  = $clog2(PIX_N);
  localparam int WAW  = $clog2(NUM_MAPS * KK);
  localparam int YAW  = $clog2(TOTAL);
  localparam int KAW  = $clog2(KK);
  localparam int MAPW = $clog2(NUM_MAPS);
  localparam int TW   = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

endpackage

// File: rtl/conv_seq_collect.sv
// Result collector: linear result-buffer writer, drain timer, overflow and timeout detection.
module conv_seq_collect
  import conv_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           busy,
  input  logic           drain,
  input  logic           eng_valid,
  input  logic [YW-1:0]  eng_y,
  output logic           ywe,
  output logic [YAW-1:0] yaddr,
  output logic [YW-1:0]  ydata,
  output logic           done,
  output logic           err
);

  logic [YAW-1:0] cnt;
  logic [TW-1:0]  timer;
  logic           err_q;
  logic           full;
  logic           timeout;

  // Timeout fires on the cycle the idle gap reaches DRAIN_MAX so done and err rise together.
  assign full    = (cnt == YAW'(TOTAL));
  assign timeout = drain && !eng_valid && (timer == TW'(DRAIN_MAX - 1));
  assign done    = drain && (full || timeout);
  assign ywe     = busy && eng_valid && !full;
  assign yaddr   = ywe ? cnt : '0;
  assign ydata   = ywe ? eng_y : '0;
  assign err     = err_q || timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      timer <= '0;
      err_q <= 1'b0;
    end else begin
      if (start)
        cnt <= '0;
      else if (ywe)
        cnt <= cnt + 1'b1;

      if (start)
        err_q <= 1'b0;
      else if ((busy && eng_valid && full) || timeout)
        err_q <= 1'b1;

      if (!drain || eng_valid)
        timer <= '0;
      else
        timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Multi-map convolution sequencer: FSM plus issue/align pipeline feeding the engine.
// Optional CONV_SEQ_PERF_EN adds a 32-bit busy-cycle counter on oCycles.
module conv_sequencer
  import conv_seq_pkg::*;
(
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  output logic            oBusy,
  output logic            oDone,
  output logic            oErr,
  output logic [MAPW-1:0] oMap,
  output logic            oXRdEn,
  output logic [XAW-1:0]  oXRdAddr,
  input  logic [DW-1:0]   iXRdData,
  output logic            oWRdEn,
  output logic [WAW-1:0]  oWRdAddr,
  input  logic [DW-1:0]   iWRdData,
  output logic            oEngValid,
  output logic            oEngWren,
  output logic [KAW-1:0]  oEngADDR,
  output logic [DW-1:0]   oEngX,
  output logic [DW-1:0]   oEngW,
  input  logic            iEngValid,
  input  logic [YW-1:0]   iEngY,
  output logic            oYWe,
  output logic [YAW-1:0]  oYAddr,
  output logic [YW-1:0]   oYData
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]     oCycles
`endif
);

  state_t          state, state_next;
  logic [XAW-1:0]  pix;
  logic [MAPW-1:0] map;
  logic            last_beat;
  logic            start_ok;
  logic            run_end;
  logic            in_drain;
  logic            eng_valid_q;
  logic            eng_wren_q;
  logic [KAW-1:0]  eng_addr_q;

  assign last_beat = (map == MAPW'(NUM_MAPS - 1)) && (pix == XAW'(PIX_N - 1));
  assign start_ok  = (state == IDLE) && iStart;
  assign in_drain  = (state == DRAIN);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: default assignment first keeps this comb block from inferring a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (iStart)    state_next = STREAM;
      STREAM:  if (last_beat) state_next = DRAIN;
      DRAIN:   if (run_end)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pix <= '0;
      map <= '0;
    end else if (state == STREAM) begin
      pix <= pix + 1'b1;
      if (pix == XAW'(PIX_N - 1))
        map <= last_beat ? '0 : map + 1'b1;
    end else begin
      pix <= '0;
      map <= '0;
    end
  end

  // Engine controls lag the reads by one cycle to line up with sync-read data.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      eng_valid_q <= 1'b0;
      eng_wren_q  <= 1'b0;
      eng_addr_q  <= '0;
    end else begin
      eng_valid_q <= oXRdEn;
      eng_wren_q  <= oWRdEn;
      eng_addr_q  <= oWRdEn ? KAW'(pix) : '0;
    end
  end

  always_comb begin
    oBusy     = (state != IDLE);
    oMap      = map;
    oXRdEn    = (state == STREAM);
    oXRdAddr  = oXRdEn ? pix : '0;
    oWRdEn    = oXRdEn && (pix < XAW'(KK));
    oWRdAddr  = oWRdEn ? (WAW'(map) * WAW'(KK) + WAW'(pix)) : '0;
    oEngValid = eng_valid_q;
    oEngWren  = eng_wren_q;
    oEngADDR  = eng_addr_q;
    oEngX     = eng_valid_q ? iXRdData : '0;
    oEngW     = eng_wren_q ? iWRdData : '0;
  end

  conv_seq_collect u_collect (
    .clk       (iCLK),
    .rst       (iRST),
    .start     (start_ok),
    .busy      (oBusy),
    .drain     (in_drain),
    .eng_valid (iEngValid),
    .eng_y     (iEngY),
    .ywe       (oYWe),
    .yaddr     (oYAddr),
    .ydata     (oYData),
    .done      (run_end),
    .err       (oErr)
  );

  assign oDone = run_end;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] cycles;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)          cycles <= '0;
    else if (start_ok) cycles <= '0;
    else if (oBusy)    cycles <= cycles + 1'b1;
  end

  assign oCycles = cycles;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: scenario table, memory/engine models, reset/abort sequences.
`timescale 1ns/1ps
module tb_conv_sequencer;

  localparam int IMG_W     = 32;
  localparam int K         = 5;
  localparam int NUM_MAPS  = 6;
  localparam int DRAIN_MAX = 64;
  localparam int LAT       = 10;
  localparam int PIX_N     = IMG_W * IMG_W;
  localparam int KK        = K * K;
  localparam int OUT_PIX   = (IMG_W - K + 1) * (IMG_W - K + 1);
  localparam int TOTAL     = NUM_MAPS * OUT_PIX;
  localparam int BEATS     = NUM_MAPS * PIX_N;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iStart;
  logic        oBusy, oDone, oErr;
  logic [2:0]  oMap;
  logic        oXRdEn;
  logic [9:0]  oXRdAddr;
  logic [7:0]  iXRdData;
  logic        oWRdEn;
  logic [7:0]  oWRdAddr;
  logic [7:0]  iWRdData;
  logic        oEngValid, oEngWren;
  logic [4:0]  oEngADDR;
  logic [7:0]  oEngX, oEngW;
  logic        iEngValid;
  logic [15:0] iEngY;
  logic        oYWe;
  logic [12:0] oYAddr;
  logic [15:0] oYData;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0] oCycles;
`endif

  conv_sequencer dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iStart    (iStart),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oErr      (oErr),
    .oMap      (oMap),
    .oXRdEn    (oXRdEn),
    .oXRdAddr  (oXRdAddr),
    .iXRdData  (iXRdData),
    .oWRdEn    (oWRdEn),
    .oWRdAddr  (oWRdAddr),
    .iWRdData  (iWRdData),
    .oEngValid (oEngValid),
    .oEngWren  (oEngWren),
    .oEngADDR  (oEngADDR),
    .oEngX     (oEngX),
    .oEngW     (oEngW),
    .iEngValid (iEngValid),
    .iEngY     (iEngY),
    .oYWe      (oYWe),
    .oYAddr    (oYAddr),
    .oYData    (oYData)
`ifdef CONV_SEQ_PERF_EN
    ,
    .oCycles   (oCycles)
`endif
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    string name;
    int    n_res;       // results the engine model emits
    bit    every;       // emit one result per beat instead of per valid window position
    bit    restart;     // pulse iStart again mid-stream
    bit    ramp;        // ramp pixels instead of random ones
    bit    chk_timeout;
    int    exp_writes;
    bit    exp_err;
  } scen_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats, issues, writes, dones, done_cyc, last_res_cyc, n_sched, res_limit;
  int wren_cnt [NUM_MAPS];
  int mon_m, mon_p;
  bit res_every, err_at_done;
  int q_due [$];
  logic [15:0] y_emit [$];
  logic [7:0] pix_mem [PIX_N];
  logic [7:0] wt_mem [NUM_MAPS*KK];
  scen_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sync-read buffers, one cycle latency.
  always @(posedge iCLK) begin
    if (oXRdEn) iXRdData <= pix_mem[oXRdAddr];
    if (oWRdEn) iWRdData <= wt_mem[oWRdAddr];
  end

  // Engine model: each beat that lands in the valid output window yields a result LAT cycles later.
  initial begin
    iEngValid = 1'b0;
    iEngY     = '0;
    forever begin
      @(posedge iCLK);
      cyc++;
      #1;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        void'(q_due.pop_front());
        iEngValid = 1'b1;
        iEngY     = 16'($urandom);
        y_emit.push_back(iEngY);
        last_res_cyc = cyc;
      end else begin
        iEngValid = 1'b0;
        iEngY     = '0;
      end
    end
  end

  // Monitor: expected beat/read/write values derived from beat index.
  initial forever begin
    @(negedge iCLK);
    if (oXRdEn) begin
      check("xrd_addr", oXRdAddr, issues % PIX_N);
      check("map", oMap, issues / PIX_N);
      if (issues % PIX_N < KK) begin
        check("wrd_en", oWRdEn, 1);
        check("wrd_addr", oWRdAddr, (issues / PIX_N) * KK + issues % PIX_N);
      end else begin
        check("wrd_en", oWRdEn, 0);
      end
      issues++;
    end
    if (oEngValid) begin
      mon_m = beats / PIX_N;
      mon_p = beats % PIX_N;
      check("eng_x", oEngX, pix_mem[mon_p]);
      if (mon_p < KK) begin
        check("eng_wren", oEngWren, 1);
        check("eng_addr", oEngADDR, mon_p);
        check("eng_w", oEngW, (mon_m * KK + mon_p) % 256);
        if (mon_m < NUM_MAPS) wren_cnt[mon_m]++;
      end else begin
        check("eng_wren", oEngWren, 0);
        check("eng_addr", oEngADDR, 0);
        check("eng_w", oEngW, 0);
      end
      if ((res_every || (mon_p / IMG_W >= K - 1 && mon_p % IMG_W >= K - 1)) && n_sched < res_limit) begin
        q_due.push_back(cyc + LAT);
        n_sched++;
      end
      beats++;
    end
    if (oYWe) begin
      check("y_addr", oYAddr, writes);
      if (writes < y_emit.size()) check("y_data", oYData, y_emit[writes]);
      else check("y_data_present", 0, 1);
      writes++;
    end
    if (oDone) begin
      dones++;
      done_cyc    = cyc;
      err_at_done = oErr;
    end
  end

  task automatic prepare(input bit ramp, input int n_res, input bit every);
    for (int a = 0; a < PIX_N; a++) pix_mem[a] = ramp ? 8'(a) : 8'($urandom);
    beats = 0; issues = 0; writes = 0; dones = 0; n_sched = 0;
    foreach (wren_cnt[i]) wren_cnt[i] = 0;
    q_due.delete();
    y_emit.delete();
    res_limit = n_res;
    res_every = every;
  endtask

  task automatic run_scenario(input scen_t sc, input bit chk_latency);
    int s;
    prepare(sc.ramp, sc.n_res, sc.every);
    @(posedge iCLK); #1;
    iStart = 1'b1;
    s = cyc;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    if (chk_latency) begin
      @(negedge iCLK);
      check({sc.name, "_lat_xrd_en"}, oXRdEn, 1);
      check({sc.name, "_lat_xrd_addr"}, oXRdAddr, 0);
      check({sc.name, "_lat_busy"}, oBusy, 1);
      @(negedge iCLK);
      check({sc.name, "_lat_eng_valid"}, oEngValid, 1);
      check({sc.name, "_lat_eng_x"}, oEngX, pix_mem[0]);
    end
    for (int i = 0; i < 9000 && dones == 0; i++) begin
      @(posedge iCLK); #1;
      if (sc.restart && i == 200) begin
        check({sc.name, "_busy_at_restart"}, oBusy, 1);
        iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
      end
    end
    check({sc.name, "_done_within_budget"}, (dones > 0), 1);
    repeat (100) @(posedge iCLK);
    #1;
    check({sc.name, "_beats"}, beats, BEATS);
    check({sc.name, "_issues"}, issues, BEATS);
    check({sc.name, "_writes"}, writes, sc.exp_writes);
    check({sc.name, "_dones"}, dones, 1);
    check({sc.name, "_err_at_done"}, err_at_done, sc.exp_err);
    check({sc.name, "_err_sticky"}, oErr, sc.exp_err);
    check({sc.name, "_idle"}, oBusy, 0);
    for (int m = 0; m < NUM_MAPS; m++) check({sc.name, "_wren_per_map"}, wren_cnt[m], KK);
    if (sc.chk_timeout) check({sc.name, "_timeout_gap"}, done_cyc - last_res_cyc, DRAIN_MAX);
`ifdef CONV_SEQ_PERF_EN
    check({sc.name, "_cycles"}, oCycles, done_cyc - s);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, oBusy, 0);
    check({tag, "_done"}, oDone, 0);
    check({tag, "_err"}, oErr, 0);
    check({tag, "_map"}, oMap, 0);
    check({tag, "_xrd_en"}, oXRdEn, 0);
    check({tag, "_xrd_addr"}, oXRdAddr, 0);
    check({tag, "_wrd_en"}, oWRdEn, 0);
    check({tag, "_eng_valid"}, oEngValid, 0);
    check({tag, "_eng_wren"}, oEngWren, 0);
    check({tag, "_eng_x"}, oEngX, 0);
    check({tag, "_ywe"}, oYWe, 0);
  endtask

  initial begin
    tbl[0] = '{name: "normal",   n_res: TOTAL,     every: 1'b0, restart: 1'b0, ramp: 1'b1,
               chk_timeout: 1'b0, exp_writes: TOTAL,     exp_err: 1'b0};
    tbl[1] = '{name: "timeout",  n_res: TOTAL - 4, every: 1'b0, restart: 1'b0, ramp: 1'b0,
               chk_timeout: 1'b1, exp_writes: TOTAL - 4, exp_err: 1'b1};
    tbl[2] = '{name: "overflow", n_res: TOTAL + 1, every: 1'b1, restart: 1'b1, ramp: 1'b0,
               chk_timeout: 1'b0, exp_writes: TOTAL,     exp_err: 1'b1};
    tbl[3] = '{name: "rerun",    n_res: TOTAL,     every: 1'b0, restart: 1'b0, ramp: 1'b0,
               chk_timeout: 1'b0, exp_writes: TOTAL,     exp_err: 1'b0};
    for (int a = 0; a < NUM_MAPS * KK; a++) wt_mem[a] = 8'(a);
    prepare(1'b1, 0, 1'b0);
    iStart = 1'b0;
    iRST   = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    repeat (5) @(posedge iCLK);
    #1;
    check("post_reset_busy", oBusy, 0);
    check("post_reset_no_reads", issues, 0);
    iRST = 1'b1;
    #1;
    check_all_zero("idle_reset");
    @(posedge iCLK); #1;
    iRST = 1'b0;

    for (int i = 0; i < 3; i++) run_scenario(tbl[i], (i == 0));

    // Abort mid-run at beat 3000.
    prepare(1'b0, TOTAL, 1'b0);
    @(posedge iCLK); #1;
    iStart = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    for (int i = 0; i < 5000 && beats < 3000; i++) @(posedge iCLK);
    #1;
    check("abort_reached_beat", (beats >= 3000), 1);
    iRST = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    repeat (5) @(posedge iCLK);
    #1;
    check("abort_no_done", dones, 0);
    check("abort_idle", oBusy, 0);

    run_scenario(tbl[3], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
